// File: rtl/phv_stage_link.sv
`default_nettype none
// ============================================================================
// Module   : phv_stage_link
// Purpose  : Buffers PHVs between two RMT match-action stages. A small FIFO
//            soaks up bursts from the upstream stage and releases one PHV per
//            cycle whenever the downstream stage asserts stg_ready_in. The
//            upstream side gets an almost_full warning, and PHVs that arrive
//            while the FIFO is full (with no pop that cycle) are dropped. The
//            control-path AXI-Stream goes through a one-cycle register slice.
// Ports    : axis_clk, aresetn          clock, async active-low reset
//            phv_in, phv_in_valid       upstream PHV and single-cycle strobe
//            stg_ready_in               downstream can take a PHV this cycle
//            phv_out, phv_out_valid     released PHV and single-cycle strobe
//            almost_full, occupancy     FIFO fill status
//            drop_cnt                   saturating overflow counter (optional)
//            c_s_axis_*  / c_m_axis_*   control-path stream in / out
// Options  : define PHV_LINK_DROP_CNT_EN to add the drop_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module phv_stage_link #(
    parameter int PHV_LEN              = 48*8 + 32*8 + 16*8 + 5*20 + 256,
    parameter int DEPTH_BITS           = 3,
    parameter int AF_THRESH            = 5,
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                axis_clk,
    input  logic                                aresetn,

    input  logic [PHV_LEN-1:0]                  phv_in,
    input  logic                                phv_in_valid,
    input  logic                                stg_ready_in,

    output logic [PHV_LEN-1:0]                  phv_out,
    output logic                                phv_out_valid,
    output logic                                almost_full,
    output logic [DEPTH_BITS:0]                 occupancy,
`ifdef PHV_LINK_DROP_CNT_EN
    output logic [31:0]                         drop_cnt,
`endif

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_s_axis_tkeep,
    input  logic                                c_s_axis_tvalid,
    input  logic                                c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
    output logic                                c_m_axis_tvalid,
    output logic                                c_m_axis_tlast
);

    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] C_DEPTH  = DEPTH[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] C_AF_THR = AF_THRESH[DEPTH_BITS:0];

    // ------------------------------------------------------------------------
    // Storage and FIFO state
    // ------------------------------------------------------------------------
    logic [PHV_LEN-1:0]    mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wp_q;
    logic [DEPTH_BITS-1:0] rp_q;
    logic [DEPTH_BITS:0]   occ_q;
    logic [DEPTH_BITS:0]   occ_d;
    logic [PHV_LEN-1:0]    phv_out_q;
    logic                  phv_out_valid_q;

    logic w_pop;
    logic w_push;

    always_comb begin
        // No bypass: an empty FIFO never pops, even if a push lands this cycle.
        w_pop  = stg_ready_in && (occ_q != '0);
        // A full FIFO still accepts a push when a pop frees a slot in the same
        // cycle, so sustained 1 PHV/cycle flow works at full occupancy.
        w_push = phv_in_valid && ((occ_q != C_DEPTH) || w_pop);

        occ_d = occ_q;
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // RAM array carries no reset; its content is meaningless while occ_q is 0.
    always_ff @(posedge axis_clk) begin
        if (w_push) begin
            mem_q[wp_q] <= phv_in;
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wp_q            <= '0;
            rp_q            <= '0;
            occ_q           <= '0;
            phv_out_q       <= '0;
            phv_out_valid_q <= 1'b0;
        end else begin
            occ_q           <= occ_d;
            phv_out_valid_q <= w_pop;
            if (w_push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (w_pop) begin
                phv_out_q <= mem_q[rp_q];
                rp_q      <= rp_q + 1'b1;
            end
        end
    end

    assign phv_out       = phv_out_q;
    assign phv_out_valid = phv_out_valid_q;
    assign occupancy     = occ_q;
    assign almost_full   = (occ_q >= C_AF_THR);

    // ------------------------------------------------------------------------
    // Overflow accounting
    // ------------------------------------------------------------------------
`ifdef PHV_LINK_DROP_CNT_EN
    logic [31:0] drop_cnt_q;
    logic        w_drop;

    assign w_drop = phv_in_valid && !w_push;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
        end else if (w_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Without the counter, overflow PHVs simply never reach the RAM.
`endif

    // ------------------------------------------------------------------------
    // Control-path register slice: unconditional, no backpressure
    // ------------------------------------------------------------------------
    logic [C_S_AXIS_DATA_WIDTH-1:0]   c_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  c_tuser_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] c_tkeep_q;
    logic                             c_tvalid_q;
    logic                             c_tlast_q;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            c_tdata_q  <= '0;
            c_tuser_q  <= '0;
            c_tkeep_q  <= '0;
            c_tvalid_q <= 1'b0;
            c_tlast_q  <= 1'b0;
        end else begin
            c_tdata_q  <= c_s_axis_tdata;
            c_tuser_q  <= c_s_axis_tuser;
            c_tkeep_q  <= c_s_axis_tkeep;
            c_tvalid_q <= c_s_axis_tvalid;
            c_tlast_q  <= c_s_axis_tlast;
        end
    end

    assign c_m_axis_tdata  = c_tdata_q;
    assign c_m_axis_tuser  = c_tuser_q;
    assign c_m_axis_tkeep  = c_tkeep_q;
    assign c_m_axis_tvalid = c_tvalid_q;
    assign c_m_axis_tlast  = c_tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_phv_stage_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_phv_stage_link
// Purpose  : Self-checking bench for phv_stage_link. A queue-based reference
//            model predicts every output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phv_stage_link;

    localparam int PHV_LEN = 1124;
    localparam int DEPTH   = 8;
    localparam int AF      = 5;
    localparam int DW      = 512;
    localparam int UW      = 128;
    localparam int KW      = DW / 8;

    logic              axis_clk;
    logic              aresetn;
    logic [PHV_LEN-1:0] phv_in;
    logic              phv_in_valid;
    logic              stg_ready_in;
    logic [PHV_LEN-1:0] phv_out;
    logic              phv_out_valid;
    logic              almost_full;
    logic [3:0]        occupancy;
`ifdef PHV_LINK_DROP_CNT_EN
    logic [31:0]       drop_cnt;
`endif
    logic [DW-1:0]     c_s_axis_tdata;
    logic [UW-1:0]     c_s_axis_tuser;
    logic [KW-1:0]     c_s_axis_tkeep;
    logic              c_s_axis_tvalid;
    logic              c_s_axis_tlast;
    logic [DW-1:0]     c_m_axis_tdata;
    logic [UW-1:0]     c_m_axis_tuser;
    logic [KW-1:0]     c_m_axis_tkeep;
    logic              c_m_axis_tvalid;
    logic              c_m_axis_tlast;

    phv_stage_link #(
        .PHV_LEN              (PHV_LEN),
        .DEPTH_BITS           (3),
        .AF_THRESH            (AF),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW)
    ) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .stg_ready_in    (stg_ready_in),
        .phv_out         (phv_out),
        .phv_out_valid   (phv_out_valid),
        .almost_full     (almost_full),
        .occupancy       (occupancy),
`ifdef PHV_LINK_DROP_CNT_EN
        .drop_cnt        (drop_cnt),
`endif
        .c_s_axis_tdata  (c_s_axis_tdata),
        .c_s_axis_tuser  (c_s_axis_tuser),
        .c_s_axis_tkeep  (c_s_axis_tkeep),
        .c_s_axis_tvalid (c_s_axis_tvalid),
        .c_s_axis_tlast  (c_s_axis_tlast),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [PHV_LEN-1:0] mq [$];
    logic               exp_valid;
    logic [PHV_LEN-1:0] exp_out;
    logic [31:0]        exp_drop;
    logic [DW-1:0]      exp_tdata;
    logic [UW-1:0]      exp_tuser;
    logic [KW-1:0]      exp_tkeep;
    logic               exp_tvalid;
    logic               exp_tlast;

    int  n_cmp  = 0;
    int  n_fail = 0;
    logic hold_ctrl = 1'b0;

    task automatic cmp(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1279:0] po;
        logic [1279:0] pe;
        po = '0;
        pe = '0;
        po[PHV_LEN-1:0] = phv_out;
        pe[PHV_LEN-1:0] = exp_out;
        cmp("phv_out_valid", 512'(phv_out_valid), 512'(exp_valid));
        cmp("occupancy",     512'(occupancy),     512'(mq.size()));
        cmp("almost_full",   512'(almost_full),   512'(mq.size() >= AF));
        for (int k = 0; k < 5; k++) begin
            cmp($sformatf("phv_out[%0d]", k), 512'(po[k*256 +: 256]), 512'(pe[k*256 +: 256]));
        end
        cmp("c_m_tdata",  c_m_axis_tdata,          exp_tdata);
        cmp("c_m_tuser",  512'(c_m_axis_tuser),    512'(exp_tuser));
        cmp("c_m_tkeep",  512'(c_m_axis_tkeep),    512'(exp_tkeep));
        cmp("c_m_tvalid", 512'(c_m_axis_tvalid),   512'(exp_tvalid));
        cmp("c_m_tlast",  512'(c_m_axis_tlast),    512'(exp_tlast));
`ifdef PHV_LINK_DROP_CNT_EN
        cmp("drop_cnt",   512'(drop_cnt),          512'(exp_drop));
`endif
    endtask

    function automatic logic [PHV_LEN-1:0] rand_phv();
        logic [1151:0] t;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom;
        return t[PHV_LEN-1:0];
    endfunction

    task automatic rand_ctrl();
        for (int i = 0; i < DW/32; i++) c_s_axis_tdata[i*32 +: 32] = $urandom;
        for (int i = 0; i < UW/32; i++) c_s_axis_tuser[i*32 +: 32] = $urandom;
        for (int i = 0; i < KW/32; i++) c_s_axis_tkeep[i*32 +: 32] = $urandom;
        c_s_axis_tvalid = 1'($urandom);
        c_s_axis_tlast  = 1'($urandom);
    endtask

    task automatic model_clear();
        mq.delete();
        exp_valid  = 1'b0;
        exp_out    = '0;
        exp_drop   = '0;
        exp_tdata  = '0;
        exp_tuser  = '0;
        exp_tkeep  = '0;
        exp_tvalid = 1'b0;
        exp_tlast  = 1'b0;
    endtask

    // Called at a falling edge: drive, take one rising edge, check, and return
    // at the next falling edge.
    task automatic step(input logic v, input logic [PHV_LEN-1:0] d, input logic r);
        bit pop;
        bit push;
        phv_in_valid = v;
        phv_in       = d;
        stg_ready_in = r;
        if (!hold_ctrl) rand_ctrl();
        @(posedge axis_clk);
        pop  = r && (mq.size() != 0);
        push = v && ((mq.size() < DEPTH) || pop);
        exp_valid = pop;
        if (pop) exp_out = mq.pop_front();
        if (push) mq.push_back(d);
        else if (v && exp_drop != 32'hFFFF_FFFF) exp_drop = exp_drop + 1;
        exp_tdata  = c_s_axis_tdata;
        exp_tuser  = c_s_axis_tuser;
        exp_tkeep  = c_s_axis_tkeep;
        exp_tvalid = c_s_axis_tvalid;
        exp_tlast  = c_s_axis_tlast;
        #1;
        check_all();
        @(negedge axis_clk);
    endtask

    // Called at a falling edge; asserts reset mid-cycle, returns with reset
    // released at a falling edge.
    task automatic do_reset();
        #2;
        aresetn = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge axis_clk);
        #1;
        check_all();
        @(negedge axis_clk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [PHV_LEN-1:0] p;
        aresetn      = 1'b1;
        phv_in       = '0;
        phv_in_valid = 1'b0;
        stg_ready_in = 1'b0;
        c_s_axis_tdata  = '0;
        c_s_axis_tuser  = '0;
        c_s_axis_tkeep  = '0;
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
        #1;
        aresetn = 1'b0;
        #2;
        model_clear();
        check_all();
        @(negedge axis_clk);
        @(negedge axis_clk);
        aresetn = 1'b1;

        // Single PHV ending in A5 with ready high: visible two edges later.
        p = rand_phv();
        p[7:0] = 8'hA5;
        step(1'b1, p, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, rand_phv(), 1'b1);

        // Burst 1..8 with ready low, then 3 overflow PHVs, then drain.
        for (int i = 1; i <= 8; i++) step(1'b1, PHV_LEN'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rand_phv(), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, rand_phv(), 1'b1);

        // Full FIFO with simultaneous push of 9 and pop: drain order 2..9.
        for (int i = 1; i <= 8; i++) step(1'b1, PHV_LEN'(i), 1'b0);
        step(1'b1, PHV_LEN'(9), 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, rand_phv(), 1'b1);

        // Empty FIFO with push and ready together: no bypass.
        step(1'b1, rand_phv(), 1'b1);
        step(1'b1, rand_phv(), 1'b1);
        step(1'b0, rand_phv(), 1'b1);
        step(1'b0, rand_phv(), 1'b1);

        // Reset with occupancy 4 and an output just released.
        for (int i = 0; i < 4; i++) step(1'b1, rand_phv(), 1'b0);
        step(1'b1, rand_phv(), 1'b1);
        do_reset();
        step(1'b1, rand_phv(), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, rand_phv(), 1'b1);

        // Three-beat control packet alongside PHV traffic.
        hold_ctrl = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            rand_ctrl();
            c_s_axis_tvalid = 1'b1;
            c_s_axis_tlast  = (b == 3);
            step(1'($urandom), rand_phv(), 1'($urandom));
        end
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
        step(1'b0, rand_phv(), 1'b1);
        hold_ctrl = 1'b0;

        // Random traffic, biased phases to exercise both full and empty.
        for (int i = 0; i < 400; i++) begin
            int pv;
            int pr;
            pv = (i % 100 < 50) ? 85 : 40;
            pr = (i % 100 < 50) ? 30 : 80;
            step(($urandom_range(99) < pv), rand_phv(), ($urandom_range(99) < pr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phv_stage_link.md
# phv_stage_link

Inter-stage PHV buffer placed between the `phv_out`/`phv_out_valid` of one RMT match-action stage and the `phv_in`/`phv_in_valid` of the next. It absorbs PHVs in a small FIFO and releases them only while the downstream stage asserts `stg_ready`. It gives the upstream side an early `almost_full` warning and drops PHVs on overflow. The control-path AXI-Stream passes through a one-cycle register slice, so stage-to-stage config packets keep their ordering.

## Interface
- `PHV_LEN`, 48\*8+32\*8+16\*8+5\*20+256 (=1124): PHV width.
- `DEPTH_BITS`, 3: FIFO depth = 2^DEPTH_BITS (8).
- `AF_THRESH`, 5: `almost_full` asserts when occupancy ≥ AF_THRESH; legal range 1..2^DEPTH_BITS.
- `C_S_AXIS_DATA_WIDTH`, 512: control-path tdata width.
- `C_S_AXIS_TUSER_WIDTH`, 128: control-path tuser width.

Ports:
- `axis_clk`  in  1  sole clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `phv_in`  in  PHV_LEN  PHV from the upstream stage.
- `phv_in_valid`  in  1  single-cycle strobe; one PHV per asserted cycle.
- `stg_ready_in`  in  1  downstream stage can accept a PHV this cycle.
- `phv_out`  out  PHV_LEN  PHV to the downstream stage.
- `phv_out_valid`  out  1  single-cycle strobe per released PHV.
- `almost_full`  out  1  occupancy ≥ AF_THRESH.
- `occupancy`  out  DEPTH_BITS+1  current FIFO entry count.
- `drop_cnt`  out  32  overflow drop count; present only with PHV_LINK_DROP_CNT_EN.
- `c_s_axis_tdata/tuser/tkeep/tvalid/tlast`  in  512/128/64/1/1  control path in.
- `c_m_axis_tdata/tuser/tkeep/tvalid/tlast`  out  512/128/64/1/1  control path out.

## Operation
- Storage: 2^DEPTH_BITS × PHV_LEN RAM, with write pointer `wp`, read pointer `rp` (DEPTH_BITS each, natural wrap-around) and an `occupancy` counter (0..2^DEPTH_BITS).
- Push: occurs when `phv_in_valid` is high and either `occupancy < 2^DEPTH_BITS` or a pop occurs in the same cycle. The PHV is written at `wp`, then `wp` increments.
- Pop: occurs when `stg_ready_in` is high and `occupancy != 0`. The entry at `rp` is registered into `phv_out`, `phv_out_valid` is set to 1 for the following cycle, and `rp` increments. Otherwise `phv_out_valid` is 0 and `phv_out` holds its last value.
- Occupancy update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop while full: both take effect and occupancy stays at 2^DEPTH_BITS.
- Simultaneous push and pop while empty: the pop does not occur (there is no bypass). The push lands and occupancy becomes 1.
- Overflow: `phv_in_valid` arrives while full with no pop. The PHV is discarded and FIFO state is unchanged.
- `almost_full`: derived combinationally from the registered `occupancy`.
- Ordering: strictly FIFO, with no reordering.
- Control path: every c_s_* signal is registered into the matching c_m_* signal unconditionally each cycle. There is no backpressure and no filtering.
- Reset (asserted at any time, including mid-burst): pointers, occupancy, `phv_out_valid`, `phv_out`, `drop_cnt`, and all c_m_* outputs clear to 0 immediately. Buffered PHVs are lost.

## Timing
- Reset values: every output is 0; `almost_full` is 0 (occupancy 0).
- Latency when empty: PHV pushed at edge N, so `occupancy` = 1 after N. With `stg_ready_in` high, the pop occurs at edge N+1 and `phv_out_valid` is high in the cycle after N+1. Minimum latency is 2 cycles.
- Throughput: 1 PHV/cycle sustained while `stg_ready_in` stays high and input is continuous.
- `stg_ready_in` is sampled at the pop edge. Dropping it stops release starting at the next edge, with no in-flight loss.
- Control-path latency: exactly 1 cycle.

## Configuration
- `PHV_LINK_DROP_CNT_EN` defined: `drop_cnt` port exists. It increments by 1 per overflow drop and saturates at 0xFFFFFFFF.
- Not defined: the port and counter are removed, and overflow PHVs are discarded silently.

## Test plan
- Single PHV 0x…A5 with `stg_ready_in`=1: `phv_out`=0x…A5 with `phv_out_valid` high exactly 2 cycles after input, one cycle wide.
- Burst of 8 PHVs (values 1..8) with `stg_ready_in`=0: `occupancy`=8 and `almost_full`=1 from the 5th push onward. Raise ready: outputs are 1..8 on consecutive cycles, then occupancy returns to 0.
- FIFO full, then 3 more PHVs with ready=0: with macro, `drop_cnt`=3; stored contents still 1..8 on drain.
- FIFO full with simultaneous push 9 and pop: occupancy stays 8, no drop, and drain order is 2..9.
- `aresetn` pulsed low while occupancy=4 and outputs are active: all outputs read 0 within the reset cycle, and the next PHV after release appears with 2-cycle latency.
- Control packet of 3 beats with tlast on beat 3: c_m_* reproduces every beat 1 cycle later, bit-exact, independent of PHV traffic.
